fft_sequencer: RTL and testbench



---
 rtl/fft_pkg.sv | 52 +++++
 rtl/fft_wb_pipe.sv | 49 ++++
 rtl/fft_sequencer.sv | 157 +++++++++++++++
 tb/tb_fft_sequencer.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types, default sizes and address helpers for the FFT sequencer.
package fft_pkg;

  localparam int unsigned FFT_N        = 8;
  localparam int unsigned FFT_LOG2N    = 3;
  localparam int unsigned FFT_BFLY_LAT = 2;

  // Helper result widths follow the default LOG2N; raise FFT_LOG2N for larger transforms.
  localparam int unsigned FFT_AW   = FFT_LOG2N;
  localparam int unsigned FFT_TW_W = FFT_AW - 1;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StCalc,
    StFlush,
    StUnload
  } fft_state_e;

  typedef struct packed {
    logic [FFT_AW-1:0]   a;
    logic [FFT_AW-1:0]   b;
    logic [FFT_TW_W-1:0] tw;
  } bfly_addr_t;

  // Reverse the low nbits bits of v.
  function automatic logic [FFT_AW-1:0] bitrev(input int unsigned v, input int unsigned nbits);
    logic [FFT_AW-1:0] r;
    r = '0;
    for (int i = 0; i < int'(FFT_AW); i++) begin
      if (i < int'(nbits)) r[int'(nbits) - 1 - i] = v[i];
    end
    return r;
  endfunction

  // Read/write pair and twiddle index for butterfly k of stage s.
  function automatic bfly_addr_t bfly_addr(input int unsigned s, input int unsigned k,
                                           input int unsigned log2n);
    bfly_addr_t  r;
    int unsigned half;
    int unsigned pos;
    int unsigned a;
    half = 32'd1 << s;
    pos  = k & (half - 32'd1);
    a    = ((k >> s) << (s + 32'd1)) | pos;
    r.a  = FFT_AW'(a);
    r.b  = FFT_AW'(a + half);
    r.tw = FFT_TW_W'(pos << (log2n - 32'd1 - s));
    return r;
  endfunction

endpackage

// File: rtl/fft_wb_pipe.sv
// Delay line that replays each issued butterfly address pair as a write-back LAT cycles later.
module fft_wb_pipe
  import fft_pkg::*;
#(
  parameter int unsigned LAT = FFT_BFLY_LAT,
  parameter int unsigned AW  = FFT_LOG2N
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_valid,
  input  logic [AW-1:0] i_addr_a,
  input  logic [AW-1:0] i_addr_b,
  output logic          o_we,
  output logic [AW-1:0] o_addr_a,
  output logic [AW-1:0] o_addr_b
);

  logic          r_vld [LAT];
  logic [AW-1:0] r_a   [LAT];
  logic [AW-1:0] r_b   [LAT];

  // Shift valid and address pairs one stage per cycle; reset drops anything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(LAT); i++) begin
        r_vld[i] <= 1'b0;
        r_a[i]   <= '0;
        r_b[i]   <= '0;
      end
    end else begin
      r_vld[0] <= i_valid;
      r_a[0]   <= i_addr_a;
      r_b[0]   <= i_addr_b;
      for (int i = 1; i < int'(LAT); i++) begin
        r_vld[i] <= r_vld[i-1];
        r_a[i]   <= r_a[i-1];
        r_b[i]   <= r_b[i-1];
      end
    end
  end

  // Addresses read as zero whenever no write is due.
  always_comb begin
    o_we     = r_vld[LAT-1];
    o_addr_a = r_vld[LAT-1] ? r_a[LAT-1] : '0;
    o_addr_b = r_vld[LAT-1] ? r_b[LAT-1] : '0;
  end

endmodule

// File: rtl/fft_sequencer.sv
// Control sequencer for the in-place radix-2 DIT FFT: load, per-stage issue/flush, unload.
module fft_sequencer
  import fft_pkg::*;
#(
  parameter int unsigned N        = FFT_N,
  parameter int unsigned LOG2N    = FFT_LOG2N,
  parameter int unsigned BFLY_LAT = FFT_BFLY_LAT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ld_we,
  output logic [LOG2N-1:0] ld_addr,
  output logic             bf_issue,
  output logic [LOG2N-1:0] bf_raddr_a,
  output logic [LOG2N-1:0] bf_raddr_b,
  output logic [LOG2N-2:0] bf_tw_idx,
  output logic             bf_we,
  output logic [LOG2N-1:0] bf_waddr_a,
  output logic [LOG2N-1:0] bf_waddr_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LOG2N-1:0] out_addr,
  output logic             busy,
  output logic             done
);

  localparam int unsigned KW   = LOG2N - 1;
  localparam int unsigned SW   = $clog2(LOG2N);
  localparam int unsigned FW   = (BFLY_LAT > 1) ? $clog2(BFLY_LAT) : 1;
  localparam int unsigned TW_W = LOG2N - 1;

  fft_state_e       r_state, w_state_d;
  logic [LOG2N-1:0] r_ld_cnt, w_ld_cnt_d;
  logic [KW-1:0]    r_k, w_k_d;
  logic [SW-1:0]    r_s, w_s_d;
  logic [FW-1:0]    r_fl_cnt, w_fl_cnt_d;
  logic [LOG2N-1:0] r_out_cnt, w_out_cnt_d;
  bfly_addr_t       w_bf;

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StIdle;
      r_ld_cnt  <= '0;
      r_k       <= '0;
      r_s       <= '0;
      r_fl_cnt  <= '0;
      r_out_cnt <= '0;
    end else begin
      r_state   <= w_state_d;
      r_ld_cnt  <= w_ld_cnt_d;
      r_k       <= w_k_d;
      r_s       <= w_s_d;
      r_fl_cnt  <= w_fl_cnt_d;
      r_out_cnt <= w_out_cnt_d;
    end
  end

  // Next-state logic and all strobes/addresses except the write-back port.
  always_comb begin
    w_state_d   = r_state;
    w_ld_cnt_d  = r_ld_cnt;
    w_k_d       = r_k;
    w_s_d       = r_s;
    w_fl_cnt_d  = r_fl_cnt;
    w_out_cnt_d = r_out_cnt;
    in_ready    = 1'b0;
    ld_we       = 1'b0;
    ld_addr     = '0;
    bf_issue    = 1'b0;
    bf_raddr_a  = '0;
    bf_raddr_b  = '0;
    bf_tw_idx   = '0;
    out_valid   = 1'b0;
    out_addr    = '0;
    done        = 1'b0;
    busy        = (r_state != StIdle);
    w_bf        = bfly_addr(32'(r_s), 32'(r_k), LOG2N);

    unique case (r_state)
      StIdle, StLoad: begin
        in_ready = 1'b1;
        if (in_valid) begin
          ld_we   = 1'b1;
          ld_addr = LOG2N'(bitrev(32'(r_ld_cnt), LOG2N));
          if (r_ld_cnt == LOG2N'(N - 1)) begin
            w_ld_cnt_d = '0;
            w_state_d  = StCalc;
          end else begin
            w_ld_cnt_d = r_ld_cnt + LOG2N'(1);
            w_state_d  = StLoad;
          end
        end
      end
      StCalc: begin
        bf_issue   = 1'b1;
        bf_raddr_a = LOG2N'(w_bf.a);
        bf_raddr_b = LOG2N'(w_bf.b);
        bf_tw_idx  = TW_W'(w_bf.tw);
        if (r_k == KW'(N / 2 - 1)) begin
          w_k_d      = '0;
          w_fl_cnt_d = '0;
          w_state_d  = StFlush;
        end else begin
          w_k_d = r_k + KW'(1);
        end
      end
      StFlush: begin
        // Hold off the next stage until its inputs have been written back.
        if (r_fl_cnt == FW'(BFLY_LAT - 1)) begin
          w_fl_cnt_d = '0;
          if (r_s == SW'(LOG2N - 1)) begin
            w_s_d       = '0;
            w_out_cnt_d = '0;
            w_state_d   = StUnload;
          end else begin
            w_s_d     = r_s + SW'(1);
            w_state_d = StCalc;
          end
        end else begin
          w_fl_cnt_d = r_fl_cnt + FW'(1);
        end
      end
      StUnload: begin
        out_valid = 1'b1;
        out_addr  = r_out_cnt;
        if (out_ready) begin
          if (r_out_cnt == LOG2N'(N - 1)) begin
            done        = 1'b1;
            w_out_cnt_d = '0;
            w_state_d   = StIdle;
          end else begin
            w_out_cnt_d = r_out_cnt + LOG2N'(1);
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  fft_wb_pipe #(
    .LAT(BFLY_LAT),
    .AW (LOG2N)
  ) u_wb_pipe (
    .clk     (clk),
    .rst     (rst),
    .i_valid (bf_issue),
    .i_addr_a(bf_raddr_a),
    .i_addr_b(bf_raddr_b),
    .o_we    (bf_we),
    .o_addr_a(bf_waddr_a),
    .o_addr_b(bf_waddr_b)
  );

endmodule

// File: tb/tb_fft_sequencer.sv
// Directed bench for fft_sequencer with the default N=8, BFLY_LAT=2 configuration.
module tb_fft_sequencer;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic       ld_we;
  logic [2:0] ld_addr;
  logic       bf_issue;
  logic [2:0] bf_raddr_a;
  logic [2:0] bf_raddr_b;
  logic [1:0] bf_tw_idx;
  logic       bf_we;
  logic [2:0] bf_waddr_a;
  logic [2:0] bf_waddr_b;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_addr;
  logic       busy;
  logic       done;

  int n_chk  = 0;
  int n_pass = 0;

  // Hand-computed reference sequences.
  int br  [8]  = '{0, 4, 2, 6, 1, 5, 3, 7};
  int ta  [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  int tb  [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  int ttw [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

  fft_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ld_we     (ld_we),
    .ld_addr   (ld_addr),
    .bf_issue  (bf_issue),
    .bf_raddr_a(bf_raddr_a),
    .bf_raddr_b(bf_raddr_b),
    .bf_tw_idx (bf_tw_idx),
    .bf_we     (bf_we),
    .bf_waddr_a(bf_waddr_a),
    .bf_waddr_b(bf_waddr_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_addr  (out_addr),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Feed 8 samples, optionally with in_valid toggling; ends in the cycle after the last handshake.
  task automatic load_frame(input bit toggle);
    int cnt = 0;
    int cyc = 0;
    while (cnt < 8 && cyc < 32) begin
      in_valid = toggle ? ((cyc % 2) == 0) : 1'b1;
      @(negedge clk);
      check("ld_we", 32'(ld_we), 32'(in_valid));
      if (in_valid) begin
        check("ld_in_ready", 32'(in_ready), 1);
        check("ld_addr", 32'(ld_addr), br[cnt]);
        cnt++;
      end
      next_cycle();
      cyc++;
    end
    in_valid = 1'b0;
  endtask

  // Check ncyc cycles of CALC/FLUSH starting at the first CALC cycle.
  task automatic run_calc(input int ncyc);
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      bit exp_iss;
      bit exp_we;
      int idx;
      exp_iss = (cyc < 18) && ((cyc % 6) < 4);
      exp_we  = (cyc >= 2) && (cyc < 20) && (((cyc - 2) % 6) < 4);
      @(negedge clk);
      check("calc_in_ready", 32'(in_ready), 0);
      check("calc_out_valid", 32'(out_valid), 0);
      check("calc_busy", 32'(busy), 1);
      check("bf_issue", 32'(bf_issue), 32'(exp_iss));
      if (exp_iss) begin
        idx = (cyc / 6) * 4 + (cyc % 6);
        check("bf_raddr_a", 32'(bf_raddr_a), ta[idx]);
        check("bf_raddr_b", 32'(bf_raddr_b), tb[idx]);
        check("bf_tw_idx", 32'(bf_tw_idx), ttw[idx]);
      end
      check("bf_we", 32'(bf_we), 32'(exp_we));
      if (exp_we) begin
        idx = ((cyc - 2) / 6) * 4 + ((cyc - 2) % 6);
        check("bf_waddr_a", 32'(bf_waddr_a), ta[idx]);
        check("bf_waddr_b", 32'(bf_waddr_b), tb[idx]);
      end
      next_cycle();
    end
  endtask

  // Drain with the given out_ready pattern (bit j used in cycle j), then check return to IDLE.
  task automatic unload(input logic [15:0] pat, input int ncyc);
    int exp_addr = 0;
    for (int j = 0; j < ncyc; j++) begin
      out_ready = pat[j];
      @(negedge clk);
      check("out_valid", 32'(out_valid), 1);
      check("out_addr", 32'(out_addr), exp_addr);
      check("bf_we_unload", 32'(bf_we), 0);
      check("done", 32'(done), 32'(pat[j] && exp_addr == 7));
      next_cycle();
      if (pat[j]) exp_addr++;
    end
    out_ready = 1'b0;
    @(negedge clk);
    check("post_busy", 32'(busy), 0);
    check("post_in_ready", 32'(in_ready), 1);
    check("post_out_valid", 32'(out_valid), 0);
    check("post_done", 32'(done), 0);
    next_cycle();
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_bf_issue", 32'(bf_issue), 0);
    check("rst_bf_we", 32'(bf_we), 0);
    check("rst_done", 32'(done), 0);
    check("rst_ld_we", 32'(ld_we), 0);
    check("rst_addrs", 32'({ld_addr, bf_raddr_a, bf_raddr_b, bf_tw_idx, bf_waddr_a,
                            bf_waddr_b, out_addr}), 0);
    next_cycle();
    rst = 1'b0;

    // Frame 1: back-to-back load, full transform, unload with backpressure.
    load_frame(1'b0);
    run_calc(18);
    unload(16'b11_1111_1001, 10);

    // Frame 2: gappy load, then reset in stage 1 with writes in flight.
    load_frame(1'b1);
    run_calc(7);
    rst = 1'b1;
    @(negedge clk);
    check("pre_rst_issue", 32'(bf_issue), 1);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("after_rst_bf_we", 32'(bf_we), 0);
    check("after_rst_issue", 32'(bf_issue), 0);
    check("after_rst_busy", 32'(busy), 0);
    check("after_rst_in_ready", 32'(in_ready), 1);
    next_cycle();

    // Frame 3: fresh frame after the abort must replay from stage 0.
    load_frame(1'b0);
    run_calc(18);
    unload(16'hFFFF, 8);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
